// File: rtl/full_adder.sv
// Registered add/subtract cell with carry/borrow in and out, 1-cycle latency.
// Define FULL_ADDER_OVF_EN to build the signed-overflow flag; otherwise out_ovf is tied to 0.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic [WIDTH-1:0] out_s,
  output logic             out_po,
  output logic             out_ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_ci_ext;
  logic [WIDTH:0]   w_res;

  logic [WIDTH-1:0] r_s;
  logic             r_po;
  logic             r_valid;

  // Zero-extended by one bit: in subtract mode the top bit of the result is the borrow.
  always_comb begin
    w_a_ext  = {1'b0, in_a};
    w_b_ext  = {1'b0, in_b};
    w_ci_ext = {{WIDTH{1'b0}}, in_ci};
    if (in_sub) begin
      w_res = w_a_ext - w_b_ext - w_ci_ext;
    end else begin
      w_res = w_a_ext + w_b_ext + w_ci_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s     <= '0;
      r_po    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_s  <= w_res[WIDTH-1:0];
        r_po <= w_res[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_OVF_EN
  logic [WIDTH:0] w_sa_ext;
  logic [WIDTH:0] w_sb_ext;
  logic [WIDTH:0] w_sres;
  logic           w_ovf;
  logic           r_ovf;

  // Exact signed result fits in WIDTH+1 bits; overflow when its top two bits disagree.
  always_comb begin
    w_sa_ext = {in_a[WIDTH-1], in_a};
    w_sb_ext = {in_b[WIDTH-1], in_b};
    if (in_sub) begin
      w_sres = w_sa_ext - w_sb_ext - w_ci_ext;
    end else begin
      w_sres = w_sa_ext + w_sb_ext + w_ci_ext;
    end
    w_ovf = w_sres[WIDTH] ^ w_sres[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_ovf;
    end
  end

  assign out_ovf = r_ovf;
`else
  assign out_ovf = 1'b0;
`endif

  assign out_s     = r_s;
  assign out_po    = r_po;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: WIDTH=1 and WIDTH=8 instances against an arithmetic model.
module tb_full_adder;

`ifdef FULL_ADDER_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;

  logic       in1_valid, in1_sub, in1_ci;
  logic [0:0] in1_a, in1_b;
  logic [0:0] o1_s;
  logic       o1_po, o1_ovf, o1_valid;

  logic       in8_valid, in8_sub, in8_ci;
  logic [7:0] in8_a, in8_b;
  logic [7:0] o8_s;
  logic       o8_po, o8_ovf, o8_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: what each DUT's output registers should hold.
  int e1_s, e1_po, e1_ovf, e1_v;
  int e8_s, e8_po, e8_ovf, e8_v;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in1_valid),
    .in_sub    (in1_sub),
    .in_a      (in1_a),
    .in_b      (in1_b),
    .in_ci     (in1_ci),
    .out_s     (o1_s),
    .out_po    (o1_po),
    .out_ovf   (o1_ovf),
    .out_valid (o1_valid)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in8_valid),
    .in_sub    (in8_sub),
    .in_a      (in8_a),
    .in_b      (in8_b),
    .in_ci     (in8_ci),
    .out_s     (o8_s),
    .out_po    (o8_po),
    .out_ovf   (o8_ovf),
    .out_valid (o8_valid)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Plain integer arithmetic of the operation at width w.
  function automatic void calc(input int w, input bit sub, input int a, input int b, input int ci,
                               output int s, output int po, output int ovf);
    int mod, half, t, sa, sb, r;
    mod  = 1 << w;
    half = mod / 2;
    t    = sub ? (a - b - ci) : (a + b + ci);
    s    = t & (mod - 1);
    po   = sub ? int'(a < b + ci) : int'(t >= mod);
    sa   = (a >= half) ? a - mod : a;
    sb   = (b >= half) ? b - mod : b;
    r    = sub ? (sa - sb - ci) : (sa + sb + ci);
    ovf  = (OvfEn && (r < -half || r > half - 1)) ? 1 : 0;
  endfunction

  task automatic apply(input int w, input bit rst, input bit v, input bit sub, input int a,
                       input int b, input int ci, input string tag);
    int s, po, ovf;
    rst_n = !rst;
    if (w == 1) begin
      in1_valid = v; in1_sub = sub; in1_a = 1'(a); in1_b = 1'(b); in1_ci = 1'(ci);
      in8_valid = 1'b0;
    end else begin
      in8_valid = v; in8_sub = sub; in8_a = 8'(a); in8_b = 8'(b); in8_ci = 1'(ci);
      in1_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    calc(w, sub, a, b, ci, s, po, ovf);
    if (rst) begin
      e1_s = 0; e1_po = 0; e1_ovf = 0; e1_v = 0;
      e8_s = 0; e8_po = 0; e8_ovf = 0; e8_v = 0;
    end else if (w == 1) begin
      e1_v = v; e8_v = 0;
      if (v) begin e1_s = s; e1_po = po; e1_ovf = ovf; end
    end else begin
      e8_v = v; e1_v = 0;
      if (v) begin e8_s = s; e8_po = po; e8_ovf = ovf; end
    end
    if (w == 1) begin
      check({tag, "_s"},   int'(o1_s),     e1_s);
      check({tag, "_po"},  int'(o1_po),    e1_po);
      check({tag, "_ovf"}, int'(o1_ovf),   e1_ovf);
      check({tag, "_vld"}, int'(o1_valid), e1_v);
    end else begin
      check({tag, "_s"},   int'(o8_s),     e8_s);
      check({tag, "_po"},  int'(o8_po),    e8_po);
      check({tag, "_ovf"}, int'(o8_ovf),   e8_ovf);
      check({tag, "_vld"}, int'(o8_valid), e8_v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in1_valid = 1'b0; in1_sub = 1'b0; in1_a = '0; in1_b = '0; in1_ci = 1'b0;
    in8_valid = 1'b0; in8_sub = 1'b0; in8_a = '0; in8_b = '0; in8_ci = 1'b0;

    // Reset with valid asserted must still clear everything.
    apply(8, 1'b1, 1'b1, 1'b0, 8'h12, 8'h34, 1, "rst8");
    apply(1, 1'b1, 1'b1, 1'b0, 1, 1, 1, "rst1");

    // Half-subtractor sweep, back to back.
    apply(1, 1'b0, 1'b1, 1'b1, 0, 0, 0, "hs00");
    check("hs00_lit", int'({o1_s, o1_po}), 0);
    apply(1, 1'b0, 1'b1, 1'b1, 1, 0, 0, "hs10");
    check("hs10_lit", int'({o1_s, o1_po}), 2);
    apply(1, 1'b0, 1'b1, 1'b1, 0, 1, 0, "hs01");
    check("hs01_lit", int'({o1_s, o1_po}), 3);
    apply(1, 1'b0, 1'b1, 1'b1, 1, 1, 0, "hs11");
    check("hs11_lit", int'({o1_s, o1_po}), 0);

    // WIDTH=1 add corners.
    apply(1, 1'b0, 1'b1, 1'b0, 1, 1, 1, "add111");
    check("add111_ovf_lit", int'(o1_ovf), 0);
    apply(1, 1'b0, 1'b1, 1'b0, 0, 0, 1, "add001");
    check("add001_ovf_lit", int'(o1_ovf), OvfEn ? 1 : 0);

    // WIDTH=8 add and subtract corners.
    apply(8, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h01, 0, "addFF01");
    check("addFF01_lit", int'({o8_po, o8_s}), 9'h100);
    apply(8, 1'b0, 1'b1, 1'b0, 8'h7F, 8'h01, 0, "add7F01");
    check("add7F01_lit", int'(o8_s), 8'h80);
    apply(8, 1'b0, 1'b1, 1'b1, 8'h10, 8'h20, 1, "sub1020");
    check("sub1020_lit", int'({o8_po, o8_s}), 9'h1EF);
    apply(8, 1'b0, 1'b1, 1'b1, 8'h80, 8'h01, 0, "sub8001");
    check("sub8001_ovf_lit", int'(o8_ovf), OvfEn ? 1 : 0);

    // Gating: 0x42 held while in_valid is low.
    apply(8, 1'b0, 1'b1, 1'b0, 8'h40, 8'h02, 0, "g42");
    for (int i = 0; i < 3; i++) begin
      apply(8, 1'b0, 1'b0, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1,
            "gate");
      check("gate_hold_lit", int'(o8_s), 8'h42);
    end

    // Reset mid-stream discards the in-flight operand, then 3-1 lands one cycle later.
    apply(8, 1'b0, 1'b1, 1'b0, 8'h05, 8'h06, 0, "pre_rst");
    apply(8, 1'b1, 1'b1, 1'b0, 8'hAA, 8'h55, 1, "mid_rst");
    apply(8, 1'b0, 1'b1, 1'b1, 8'h03, 8'h01, 0, "post_rst");
    check("post_rst_lit", int'({o8_po, o8_s}), 9'h002);

    // Randomized mix of widths, modes, bubbles and occasional resets.
    for (int i = 0; i < 400; i++) begin
      int w;
      w = ($urandom_range(0, 1) == 0) ? 1 : 8;
      apply(w, $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, (1 << w) - 1)), int'($urandom_range(0, (1 << w) - 1)),
            int'($urandom_range(0, 1)), (w == 1) ? "rnd1" : "rnd8");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
